// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light sequencer with a 1 s prescaler and a two-digit BCD countdown.
// Optional night flashing mode is compiled in when TRAFFIC_NIGHT_MODE_EN is defined.
module traffic_light_ctrl #(
   parameter int unsigned CLK_DIV  = 50000000,
   parameter int unsigned GREEN_T  = 25,
   parameter int unsigned YELLOW_T = 3,
   parameter int unsigned ALLRED_T = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pause,
`ifdef TRAFFIC_NIGHT_MODE_EN
   input  logic       night,
`endif
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic [3:0] count_tens,
   output logic [3:0] count_ones,
   output logic       tick
);

   localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PrescMax = PW'(CLK_DIV - 1);

   localparam logic [3:0] GrnTens = 4'(GREEN_T / 10);
   localparam logic [3:0] GrnOnes = 4'(GREEN_T % 10);
   localparam logic [3:0] YelTens = 4'(YELLOW_T / 10);
   localparam logic [3:0] YelOnes = 4'(YELLOW_T % 10);
   localparam logic [3:0] RedTens = 4'(ALLRED_T / 10);
   localparam logic [3:0] RedOnes = 4'(ALLRED_T % 10);

`ifdef TRAFFIC_NIGHT_MODE_EN
   typedef enum logic [2:0] {
      StNsGrn = 3'd0, StNsYel = 3'd1, StRed1 = 3'd2,
      StEwGrn = 3'd3, StEwYel = 3'd4, StRed2 = 3'd5, StNight = 3'd6
   } state_e;
`else
   typedef enum logic [2:0] {
      StNsGrn = 3'd0, StNsYel = 3'd1, StRed1 = 3'd2,
      StEwGrn = 3'd3, StEwYel = 3'd4, StRed2 = 3'd5
   } state_e;
`endif

   state_e        state_q, state_d, nxt_state;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;
   logic [3:0]    tens_q, tens_d, ones_q, ones_d;
   logic [3:0]    nxt_tens, nxt_ones;
   logic          legal;
   logic          wrap;
`ifdef TRAFFIC_NIGHT_MODE_EN
   logic          flash_q, flash_d;
`endif

   // wrap marks the edge that registers tick and steps the countdown
   always_comb begin
      wrap    = !pause && (presc_q == PrescMax);
      tick_d  = wrap;
      presc_d = presc_q;
      if (!pause) begin
         presc_d = wrap ? '0 : presc_q + PW'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      tens_d    = tens_q;
      ones_d    = ones_q;
      nxt_state = StNsGrn;
      nxt_tens  = GrnTens;
      nxt_ones  = GrnOnes;
      legal     = 1'b1;
      case (state_q)
         StNsGrn: begin nxt_state = StNsYel; nxt_tens = YelTens; nxt_ones = YelOnes; end
         StNsYel: begin nxt_state = StRed1;  nxt_tens = RedTens; nxt_ones = RedOnes; end
         StRed1:  begin nxt_state = StEwGrn; nxt_tens = GrnTens; nxt_ones = GrnOnes; end
         StEwGrn: begin nxt_state = StEwYel; nxt_tens = YelTens; nxt_ones = YelOnes; end
         StEwYel: begin nxt_state = StRed2;  nxt_tens = RedTens; nxt_ones = RedOnes; end
         StRed2:  begin nxt_state = StNsGrn; nxt_tens = GrnTens; nxt_ones = GrnOnes; end
`ifdef TRAFFIC_NIGHT_MODE_EN
         StNight: begin nxt_state = StRed2;  nxt_tens = RedTens; nxt_ones = RedOnes; end
`endif
         default: legal = 1'b0;
      endcase

      if (!legal) begin
         state_d = StNsGrn;
         tens_d  = GrnTens;
         ones_d  = GrnOnes;
      end else if (wrap) begin
`ifdef TRAFFIC_NIGHT_MODE_EN
         if (night) begin
            state_d = StNight;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
         end else if (state_q == StNight) begin
            state_d = nxt_state;
            tens_d  = nxt_tens;
            ones_d  = nxt_ones;
         end else
`endif
         if (tens_q == 4'd0 && ones_q == 4'd1) begin
            state_d = nxt_state;
            tens_d  = nxt_tens;
            ones_d  = nxt_ones;
         end else if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
         end else begin
            ones_d = ones_q - 4'd1;
         end
      end
   end

`ifdef TRAFFIC_NIGHT_MODE_EN
   // Yellow is lit on the first night second, then alternates each tick
   always_comb begin
      flash_d = flash_q;
      if (wrap) begin
         flash_d = (state_q == StNight) ? ~flash_q : 1'b1;
      end
   end
`endif

   always_comb begin
      ns_light = 3'b100;
      ew_light = 3'b100;
      case (state_q)
         StNsGrn: ns_light = 3'b001;
         StNsYel: ns_light = 3'b010;
         StEwGrn: ew_light = 3'b001;
         StEwYel: ew_light = 3'b010;
`ifdef TRAFFIC_NIGHT_MODE_EN
         StNight: begin
            ns_light = flash_q ? 3'b010 : 3'b000;
            ew_light = flash_q ? 3'b010 : 3'b000;
         end
`endif
         default: ;
      endcase
      count_tens = tens_q;
      count_ones = ones_q;
      tick       = tick_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StNsGrn;
         presc_q <= '0;
         tick_q  <= 1'b0;
         tens_q  <= GrnTens;
         ones_q  <= GrnOnes;
`ifdef TRAFFIC_NIGHT_MODE_EN
         flash_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
`ifdef TRAFFIC_NIGHT_MODE_EN
         flash_q <= flash_d;
`endif
      end
   end

endmodule
